// File: rtl/spi_capture_ctrl_if.sv
// Sniffer-side bus for spi_capture_ctrl: synchronized chip select, the two byte-receiver
// streams, and the valid/ready record stream going to the logger.
interface spi_capture_ctrl_if #(
   parameter int REC_W = 20
);
   logic             spi_cs;
   logic [7:0]       mosi_data;
   logic             mosi_valid;
   logic [7:0]       miso_data;
   logic             miso_valid;
   logic [REC_W-1:0] rec_data;
   logic             rec_valid;
   logic             rec_ready;

   modport master (
      output spi_cs, mosi_data, mosi_valid, miso_data, miso_valid, rec_ready,
      input  rec_data, rec_valid
   );

   modport slave (
      input  spi_cs, mosi_data, mosi_valid, miso_data, miso_valid, rec_ready,
      output rec_data, rec_valid
   );
endinterface

// File: rtl/spi_capture_ctrl.sv
// SPI capture controller: frames captures on chip-select edges, arbitrates MOSI/MISO bytes into
// tagged records and buffers them in a FWFT FIFO. Optional timestamp field: SPI_CAP_TIMESTAMP_EN.
module spi_capture_ctrl #(
   parameter int FIFO_DEPTH      = 16,
   parameter int MAX_FRAME_BYTES = 64,
   parameter int TS_W            = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic              abort,
   spi_capture_ctrl_if.slave bus,
   output logic              busy,
   output logic              frame_done,
   output logic [3:0]        frame_id,
   output logic              overflow,
   output logic              truncated
);

`ifdef SPI_CAP_TIMESTAMP_EN
   localparam int REC_W = 20 + TS_W;
`else
   // TS_W only widens the record when timestamps are built in.
   localparam int REC_W = 20 + 0 * TS_W;
`endif
   localparam int         AW      = $clog2(FIFO_DEPTH);
   localparam logic [6:0] MAX_CNT = 7'(MAX_FRAME_BYTES);

   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DRAIN = 2'd3} state_t;

   state_t           state_r, state_s;
   logic             cs_q_r, busy_r, frame_done_r, overflow_r, truncated_r, rr_ptr_r;
   logic [3:0]       frame_id_r;
   logic             fall_s, rise_s, flush_s, arm_s, enter_cap_s, done_s;
   logic [1:0]       valid_s, load_s, ovf_s, trunc_s, grant_s, hold_full_r;
   logic [7:0]       byte_s [2];
   logic [6:0]       cnt_r [2];
   logic [REC_W-1:0] rec_s [2];
   logic [REC_W-1:0] hold_r [2];
   logic [REC_W-1:0] mem_r [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_r, rd_ptr_r, rd_ptr_s;
   logic [AW:0]      count_r, count_s;
   logic             wr_en_s, rd_en_s, fifo_full_s, rec_valid_r;
   logic [REC_W-1:0] wdata_s, head_s, rec_data_r;

   assign fall_s      = cs_q_r & ~bus.spi_cs;
   assign rise_s      = ~cs_q_r & bus.spi_cs;
   assign flush_s     = abort && (state_r != IDLE);
   assign arm_s       = arm && !abort && (state_r == IDLE);
   assign enter_cap_s = (state_r == ARMED) && fall_s && !flush_s;
   assign valid_s     = {bus.miso_valid, bus.mosi_valid};
   assign byte_s[0]   = bus.mosi_data;
   assign byte_s[1]   = bus.miso_data;

`ifdef SPI_CAP_TIMESTAMP_EN
   logic [TS_W-1:0] ts_r;

   // Free-running timestamp, restarted at the start of every capture.
   always_ff @(posedge clk) begin
      if (rst || enter_cap_s) ts_r <= {TS_W{1'b0}};
      else                    ts_r <= ts_r + TS_W'(1'b1);
   end
`endif

   // Record assembly per channel: {ts?, frame_id, index, channel, byte}.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
`ifdef SPI_CAP_TIMESTAMP_EN
         rec_s[c] = {ts_r, frame_id_r, cnt_r[c], 1'(c), byte_s[c]};
`else
         rec_s[c] = {frame_id_r, cnt_r[c], 1'(c), byte_s[c]};
`endif
      end
   end

   // Byte-pulse disposition: the frame limit is checked before hold occupancy.
   always_comb begin
      load_s  = 2'b00;
      ovf_s   = 2'b00;
      trunc_s = 2'b00;
      for (int c = 0; c < 2; c++) begin
         if ((state_r == CAPTURE) && valid_s[c] && !flush_s) begin
            if (cnt_r[c] == MAX_CNT)  trunc_s[c] = 1'b1;
            else if (hold_full_r[c]) ovf_s[c]   = 1'b1;
            else                     load_s[c]  = 1'b1;
         end else begin
            load_s[c] = 1'b0;
         end
      end
   end

   assign fifo_full_s = (count_r == (AW+1)'(FIFO_DEPTH));

   // Arbiter: round-robin only when both holds compete; full is the registered view.
   always_comb begin
      grant_s = 2'b00;
      if (fifo_full_s)               grant_s = 2'b00;
      else if (hold_full_r == 2'b11) grant_s = rr_ptr_r ? 2'b10 : 2'b01;
      else                           grant_s = hold_full_r;
   end

   assign wr_en_s = |grant_s;
   assign wdata_s = grant_s[1] ? hold_r[1] : hold_r[0];
   assign rd_en_s = rec_valid_r & bus.rec_ready;

   // Next-state and frame completion.
   always_comb begin
      state_s = state_r;
      done_s  = 1'b0;
      if (flush_s) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    if (arm_s) state_s = ARMED;   else state_s = IDLE;
            ARMED:   if (fall_s) state_s = CAPTURE; else state_s = ARMED;
            CAPTURE: if (rise_s) state_s = DRAIN;   else state_s = CAPTURE;
            DRAIN: begin
               if (hold_full_r == 2'b00) begin
                  state_s = IDLE;
                  done_s  = 1'b1;
               end else begin
                  state_s = DRAIN;
               end
            end
            default: state_s = IDLE;
         endcase
      end
   end

   // FIFO next pointers and next head; a write into an emptying FIFO bypasses to the head.
   always_comb begin
      count_s  = count_r + (AW+1)'(wr_en_s) - (AW+1)'(rd_en_s);
      rd_ptr_s = rd_ptr_r + AW'(rd_en_s);
      if (count_s == {(AW+1){1'b0}})                          head_s = {REC_W{1'b0}};
      else if (wr_en_s && (count_r == (AW+1)'(rd_en_s)))      head_s = wdata_s;
      else                                                    head_s = mem_r[rd_ptr_s];
   end

   // State register, chip-select history and frame status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         cs_q_r       <= 1'b1;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         frame_id_r   <= 4'd0;
      end else begin
         state_r      <= state_s;
         cs_q_r       <= bus.spi_cs;
         busy_r       <= (state_s != IDLE);
         frame_done_r <= done_s;
         if (done_s) frame_id_r <= frame_id_r + 4'd1;
      end
   end

   // Sticky loss flags, cleared when a new capture is armed.
   always_ff @(posedge clk) begin
      if (rst || arm_s) begin
         overflow_r  <= 1'b0;
         truncated_r <= 1'b0;
      end else begin
         if (|ovf_s)   overflow_r  <= 1'b1;
         if (|trunc_s) truncated_r <= 1'b1;
      end
   end

   // Round-robin pointer flips only after a contested grant.
   always_ff @(posedge clk) begin
      if (rst)                                                         rr_ptr_r <= 1'b0;
      else if (!flush_s && (hold_full_r == 2'b11) && !fifo_full_s)     rr_ptr_r <= ~rr_ptr_r;
   end

   // Per-channel hold registers and byte counters.
   always_ff @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (rst || flush_s) begin
            hold_full_r[c] <= 1'b0;
            hold_r[c]      <= {REC_W{1'b0}};
            cnt_r[c]       <= 7'd0;
         end else begin
            if (enter_cap_s)    cnt_r[c] <= 7'd0;
            else if (load_s[c]) cnt_r[c] <= cnt_r[c] + 7'd1;
            if (load_s[c]) begin
               hold_full_r[c] <= 1'b1;
               hold_r[c]      <= rec_s[c];
            end else if (grant_s[c]) begin
               hold_full_r[c] <= 1'b0;
            end
         end
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      if (wr_en_s) mem_r[wr_ptr_r] <= wdata_s;
   end

   // FIFO pointers plus registered head/valid outputs.
   always_ff @(posedge clk) begin
      if (rst || flush_s) begin
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         count_r     <= {(AW+1){1'b0}};
         rec_valid_r <= 1'b0;
         rec_data_r  <= {REC_W{1'b0}};
      end else begin
         if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         rd_ptr_r    <= rd_ptr_s;
         count_r     <= count_s;
         rec_valid_r <= (count_s != {(AW+1){1'b0}});
         rec_data_r  <= head_s;
      end
   end

   assign bus.rec_data  = rec_data_r;
   assign bus.rec_valid = rec_valid_r;
   assign busy          = busy_r;
   assign frame_done    = frame_done_r;
   assign frame_id      = frame_id_r;
   assign overflow      = overflow_r;
   assign truncated     = truncated_r;

endmodule
